// File: rtl/mem_access_unit.sv
// Byte-addressed little-endian data memory behind valid/ready request and response channels.
// Supports byte/half/word accesses, sign or zero extension, fault reporting and programmable wait states.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTE_WIDTH  = 8,
  parameter int SIZE        = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int WORDS = SIZE / LANES;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W = $clog2(LANES);
  localparam int LA_W  = IDX_W + OFF_W;
  localparam logic [ADDR_WIDTH:0] SIZE_W = SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_cnt;
  logic                  r_rw;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [LA_W-1:0]       r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_err;

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rd_word;

  logic                  w_accept;
  logic                  w_commit;
  logic [1:0]            w_err;
  logic [ADDR_WIDTH:0]   w_last_off;
  logic [ADDR_WIDTH:0]   w_end;
  logic [IDX_W-1:0]      w_idx;
  logic [LANES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_lane_data;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 8'd0) && (r_err == 2'd0);
  assign w_idx    = r_addr[LA_W-1:OFF_W];

  // Fault classification on the live request; the one-bit-wider sum keeps top-of-space accesses from wrapping.
  always_comb begin
    w_last_off = '0;
    case (req_size)
      2'd0:    w_last_off = '0;
      2'd1:    w_last_off = (ADDR_WIDTH+1)'(1);
      default: w_last_off = (ADDR_WIDTH+1)'(3);
    endcase
    w_end = {1'b0, req_addr} + w_last_off;
    w_err = 2'd0;
    if (req_size == 2'd3) begin
      w_err = 2'd3;
    end else if ((req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00)) begin
      w_err = 2'd1;
    end else if (w_end >= SIZE_W) begin
      w_err = 2'd2;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == 8'd0) w_state_next = S_RESP;
      S_RESP:  if (resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Faults load a zero count so they leave WAIT on the very next edge.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt      <= 8'd0;
      r_rw       <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 2'd0;
    end else if (w_accept) begin
      r_cnt      <= (w_err == 2'd0) ? 8'(WAIT_CYCLES) : 8'd0;
      r_rw       <= req_rw;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr[LA_W-1:0];
      r_wdata    <= req_wdata;
      r_err      <= w_err;
    end else if (r_state == S_WAIT && r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end else if (r_state == S_RESP && resp_ready) begin
      r_err <= 2'd0;
    end
  end

  always_comb begin
    w_be        = '1;
    w_lane_data = r_wdata;
    case (r_size)
      2'd0: begin
        w_be        = {{(LANES-1){1'b0}}, 1'b1} << r_addr[OFF_W-1:0];
        w_lane_data = {LANES{r_wdata[BYTE_WIDTH-1:0]}};
      end
      2'd1: begin
        w_be        = {{(LANES-2){1'b0}}, 2'b11} << r_addr[OFF_W-1:0];
        w_lane_data = {(LANES/2){r_wdata[2*BYTE_WIDTH-1:0]}};
      end
      default: begin
        w_be        = '1;
        w_lane_data = r_wdata;
      end
    endcase
  end

  // Storage has no reset; a reset forces IDLE, which blocks any pending commit.
  always_ff @(posedge sys_clk) begin
    if (w_commit && r_rw) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_be[l]) begin
          r_mem[w_idx][l*BYTE_WIDTH +: BYTE_WIDTH] <= w_lane_data[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (w_commit && !r_rw) begin
      r_rd_word <= r_mem[w_idx];
    end
  end

  always_comb begin
    w_shift = r_rd_word >> {r_addr[OFF_W-1:0], 3'b000};
    case (r_size)
      2'd0: w_ext = r_unsigned ?
                    {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_shift[BYTE_WIDTH-1:0]} :
                    {{(DATA_WIDTH-BYTE_WIDTH){w_shift[BYTE_WIDTH-1]}}, w_shift[BYTE_WIDTH-1:0]};
      2'd1: w_ext = r_unsigned ?
                    {{(DATA_WIDTH-2*BYTE_WIDTH){1'b0}}, w_shift[2*BYTE_WIDTH-1:0]} :
                    {{(DATA_WIDTH-2*BYTE_WIDTH){w_shift[2*BYTE_WIDTH-1]}}, w_shift[2*BYTE_WIDTH-1:0]};
      default: w_ext = w_shift;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid ? r_err : 2'd0;
  assign resp_rdata = (resp_valid && !r_rw && r_err == 2'd0) ? w_ext : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: dut0 runs with no wait states, dut3 with three; table vectors plus handshake corner sequences.
module tb_mem_access_unit;

  logic        clk;
  logic [1:0]  rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_rw       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic [1:0]  resp_err     [2];

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.WAIT_CYCLES(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  mem_access_unit #(.WAIT_CYCLES(3)) dut3 (
    .sys_clk(clk), .sys_rst(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          d;
    logic        rw;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_err;
    int          exp_lat;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid[d]    = 1'b1;
    req_rw[d]       = rw;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wd;
  endtask

  task automatic xact(input int d, input logic rw, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] er, output int lat);
    @(negedge clk);
    drive(d, rw, sz, uns, addr, wd);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid[d]) lat = -1;
    rd = resp_rdata[d];
    er = resp_err[d];
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    $display("txn dut%0d rw=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             d, rw, sz, uns, addr, wd, rd, er, lat);
    chk("ready_after_handshake", {31'd0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    int          k;
    logic        seen;

    rst_n = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_rw[i] = 1'b0; req_size[i] = 2'd0; req_unsigned[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", {31'd0, req_ready[i]}, 32'd1);
      chk("reset_resp_valid", {31'd0, resp_valid[i]}, 32'd0);
      chk("reset_resp_rdata", resp_rdata[i], 32'd0);
      chk("reset_resp_err", {30'd0, resp_err[i]}, 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 2'b11;

    //                d rw sz uns addr          wdata         exp_rd        err lat name
    vecs.push_back('{0, 1, 2, 0, 32'h10,       32'h8899AABB, 32'h0,        0, 1, "w_word_10"});
    vecs.push_back('{0, 0, 2, 0, 32'h10,       32'h0,        32'h8899AABB, 0, 1, "r_word_10"});
    vecs.push_back('{0, 1, 0, 0, 32'h11,       32'hDEADBEF0, 32'h0,        0, 1, "w_byte_11"});
    vecs.push_back('{0, 0, 0, 0, 32'h11,       32'h0,        32'hFFFFFFF0, 0, 1, "r_byte_11_s"});
    vecs.push_back('{0, 0, 0, 1, 32'h11,       32'h0,        32'h000000F0, 0, 1, "r_byte_11_u"});
    vecs.push_back('{0, 0, 1, 0, 32'h12,       32'h0,        32'hFFFF8899, 0, 1, "r_half_12_s"});
    vecs.push_back('{0, 0, 1, 1, 32'h12,       32'h0,        32'h00008899, 0, 1, "r_half_12_u"});
    vecs.push_back('{0, 0, 2, 0, 32'h10,       32'h0,        32'h8899F0BB, 0, 1, "r_word_10_b"});
    vecs.push_back('{0, 0, 0, 0, 32'h10,       32'h0,        32'hFFFFFFBB, 0, 1, "r_byte_10_s"});
    vecs.push_back('{0, 0, 1, 1, 32'h10,       32'h0,        32'h0000F0BB, 0, 1, "r_half_10_u"});
    vecs.push_back('{0, 1, 2, 0, 32'h12,       32'h0,        32'h0,        1, 1, "w_word_12_mis"});
    vecs.push_back('{0, 0, 2, 0, 32'h10,       32'h0,        32'h8899F0BB, 0, 1, "r_word_10_c"});
    vecs.push_back('{0, 1, 2, 0, 32'h14,       32'h0,        32'h0,        0, 1, "w_word_14"});
    vecs.push_back('{0, 1, 1, 0, 32'h16,       32'hABCD8001, 32'h0,        0, 1, "w_half_16"});
    vecs.push_back('{0, 0, 2, 0, 32'h14,       32'h0,        32'h80010000, 0, 1, "r_word_14"});
    vecs.push_back('{0, 0, 1, 0, 32'h16,       32'h0,        32'hFFFF8001, 0, 1, "r_half_16_s"});
    vecs.push_back('{0, 1, 1, 0, 32'h14,       32'h00007F7F, 32'h0,        0, 1, "w_half_14"});
    vecs.push_back('{0, 0, 1, 0, 32'h14,       32'h0,        32'h00007F7F, 0, 1, "r_half_14_s"});
    vecs.push_back('{0, 0, 2, 0, 32'h14,       32'h0,        32'h80017F7F, 0, 1, "r_word_14_b"});
    vecs.push_back('{0, 1, 2, 0, 32'h3FC,      32'h11223344, 32'h0,        0, 1, "w_word_3fc"});
    vecs.push_back('{0, 0, 0, 1, 32'h3FF,      32'h0,        32'h00000011, 0, 1, "r_byte_3ff_u"});
    vecs.push_back('{0, 0, 1, 0, 32'h3FE,      32'h0,        32'h00001122, 0, 1, "r_half_3fe_s"});
    vecs.push_back('{0, 0, 1, 0, 32'h3FF,      32'h0,        32'h0,        1, 1, "r_half_3ff"});
    vecs.push_back('{0, 0, 1, 0, 32'h400,      32'h0,        32'h0,        2, 1, "r_half_400"});
    vecs.push_back('{0, 0, 2, 0, 32'h400,      32'h0,        32'h0,        2, 1, "r_word_400"});
    vecs.push_back('{0, 0, 0, 0, 32'h400,      32'h0,        32'h0,        2, 1, "r_byte_400"});
    vecs.push_back('{0, 1, 2, 0, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0,        2, 1, "w_word_top"});
    vecs.push_back('{0, 0, 3, 0, 32'h10,       32'h0,        32'h0,        3, 1, "r_size3"});
    vecs.push_back('{0, 0, 3, 0, 32'h13,       32'h0,        32'h0,        3, 1, "r_size3_mis"});
    vecs.push_back('{0, 1, 1, 0, 32'h11,       32'h5555,     32'h0,        1, 1, "w_half_11_mis"});
    vecs.push_back('{0, 0, 2, 0, 32'h3FC,      32'h0,        32'h11223344, 0, 1, "r_word_3fc"});
    vecs.push_back('{0, 0, 2, 0, 32'h10,       32'h0,        32'h8899F0BB, 0, 1, "r_word_10_d"});
    vecs.push_back('{1, 1, 2, 0, 32'h20,       32'hCAFEF00D, 32'h0,        0, 4, "w3_word_20"});
    vecs.push_back('{1, 0, 2, 0, 32'h20,       32'h0,        32'hCAFEF00D, 0, 4, "r3_word_20"});
    vecs.push_back('{1, 0, 2, 0, 32'h22,       32'h0,        32'h0,        1, 1, "r3_word_22_mis"});
    vecs.push_back('{1, 0, 1, 0, 32'h400,      32'h0,        32'h0,        2, 1, "r3_half_400"});
    vecs.push_back('{1, 1, 3, 0, 32'h20,       32'h55555555, 32'h0,        3, 1, "w3_size3"});
    vecs.push_back('{1, 0, 2, 0, 32'h20,       32'h0,        32'hCAFEF00D, 0, 4, "r3_word_20_b"});
    vecs.push_back('{1, 0, 0, 0, 32'h23,       32'h0,        32'hFFFFFFCA, 0, 4, "r3_byte_23_s"});

    foreach (vecs[i]) begin
      xact(vecs[i].d, vecs[i].rw, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, er, lat);
      chk({vecs[i].nm, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].nm, "_err"}, {30'd0, er}, {30'd0, vecs[i].exp_err});
      chk({vecs[i].nm, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // A write pulse during WAIT must be ignored.
    @(negedge clk);
    drive(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) drive(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
      if (k == 2) req_valid[1] = 1'b0;
      if (resp_valid[1]) seen = 1'b1;
      else chk("wait_req_ready_low", {31'd0, req_ready[1]}, 32'd0);
    end
    req_valid[1] = 1'b0;
    $display("txn dut3 wait-pulse read 0x20 -> rdata=0x%08h lat=%0d", resp_rdata[1], k);
    chk("wait_pulse_lat", 32'(k), 32'd4);
    chk("wait_pulse_rdata", resp_rdata[1], 32'hCAFEF00D);
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid[1]) seen = 1'b1;
    end
    chk("wait_pulse_no_extra_resp", {31'd0, seen}, 32'd0);
    xact(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("wait_pulse_mem_intact", rd, 32'hCAFEF00D);

    // Backpressure, then a request overlapping the handshake cycle.
    @(negedge clk);
    drive(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("bp_resp_valid", {31'd0, resp_valid[0]}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, resp_valid[0]}, 32'd1);
      chk("bp_hold_rdata", resp_rdata[0], 32'h8899F0BB);
      chk("bp_hold_err", {30'd0, resp_err[0]}, 32'd0);
      chk("bp_hold_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    drive(0, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    $display("txn dut0 backpressure read 0x10 released, overlapping read 0x14 pending");
    chk("bp_ready_after", {31'd0, req_ready[0]}, 32'd1);
    chk("bp_valid_after", {31'd0, resp_valid[0]}, 32'd0);
    chk("bp_rdata_after", resp_rdata[0], 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("overlap_accepted", {31'd0, req_ready[0]}, 32'd0);
    @(posedge clk); #1;
    chk("overlap_resp_valid", {31'd0, resp_valid[0]}, 32'd1);
    chk("overlap_rdata", resp_rdata[0], 32'h80017F7F);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;

    // Reset during WAIT of a write must drop it.
    @(negedge clk);
    drive(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    #1;
    $display("txn dut3 reset asserted during write 0x20");
    chk("rst_mid_req_ready", {31'd0, req_ready[1]}, 32'd1);
    chk("rst_mid_resp_valid", {31'd0, resp_valid[1]}, 32'd0);
    chk("rst_mid_rdata", resp_rdata[1], 32'd0);
    chk("rst_mid_err", {30'd0, resp_err[1]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid[1]) seen = 1'b1;
    end
    chk("rst_resp_dropped", {31'd0, seen}, 32'd0);
    xact(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rst_write_not_committed", rd, 32'hCAFEF00D);
    chk("rst_read_lat", 32'(lat), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
